// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronize, debounce and auto-repeat three pushbuttons
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_increase_n,
    input  logic key_decrease_n,
    input  logic key_change_n,
    output logic pressed_increase,
    output logic pressed_decrease,
    output logic pressed_change,
    output logic butt_increase,
    output logic butt_decrease,
    output logic butt_change
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DELAY,
        REPEAT
    } rpt_state_t;

    // Channel order everywhere: 0 = increase, 1 = decrease, 2 = change.
    logic [2:0]      raw_n;
    logic [2:0]      sync1_n;
    logic [2:0]      sync2_n;
    logic [2:0]      level;
    logic [2:0]      stable;
    logic [2:0]      stable_d;
    logic [2:0]      rise;
    logic [DB_W-1:0] db_cnt [3];
    logic            conflict;

    rpt_state_t      state    [2];
    rpt_state_t      state_nx [2];
    logic [RP_W-1:0] rpt_cnt    [2];
    logic [RP_W-1:0] rpt_cnt_nx [2];
    logic [1:0]      rpt_pulse;

    assign raw_n = {key_change_n, key_decrease_n, key_increase_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_n  <= '1;
            sync2_n  <= '1;
            level    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1_n  <= raw_n;
            sync2_n  <= sync1_n;
            level    <= ~sync2_n;
            stable_d <= stable;
            // Any cycle agreeing with the stable level restarts the debounce window.
            for (int i = 0; i < 3; i++) begin
                if (level[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise     = stable & ~stable_d;
    assign conflict = stable[0] & stable[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state[i]   <= IDLE;
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i]   <= state_nx[i];
                rpt_cnt[i] <= rpt_cnt_nx[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nx[i]   = state[i];
            rpt_cnt_nx[i] = rpt_cnt[i] + 1'b1;
            rpt_pulse[i]  = 1'b0;
            if (conflict || !stable[i]) begin
                state_nx[i]   = IDLE;
                rpt_cnt_nx[i] = '0;
            end else begin
                case (state[i])
                    IDLE: begin
                        rpt_cnt_nx[i] = '0;
                        if (rise[i]) begin
                            state_nx[i] = WAIT_DELAY;
                        end
                    end
                    WAIT_DELAY: begin
                        if (rpt_cnt[i] == DELAY_LAST) begin
                            rpt_pulse[i]  = 1'b1;
                            state_nx[i]   = REPEAT;
                            rpt_cnt_nx[i] = '0;
                        end
                    end
                    REPEAT: begin
                        if (rpt_cnt[i] == RATE_LAST) begin
                            rpt_pulse[i]  = 1'b1;
                            rpt_cnt_nx[i] = '0;
                        end
                    end
                    default: begin
                        state_nx[i]   = IDLE;
                        rpt_cnt_nx[i] = '0;
                    end
                endcase
            end
        end
    end

    // A press suppressed by the increase/decrease conflict is dropped, never deferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            butt_increase <= 1'b0;
            butt_decrease <= 1'b0;
            butt_change   <= 1'b0;
        end else begin
            butt_increase <= ~conflict & (rise[0] | rpt_pulse[0]);
            butt_decrease <= ~conflict & (rise[1] | rpt_pulse[1]);
            butt_change   <= rise[2];
        end
    end

    assign pressed_increase = stable[0];
    assign pressed_decrease = stable[1];
    assign pressed_change   = stable[2];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic key_increase_n;
    logic key_decrease_n;
    logic key_change_n;
    logic pressed_increase;
    logic pressed_decrease;
    logic pressed_change;
    logic butt_increase;
    logic butt_decrease;
    logic butt_change;

    int n_vectors     = 0;
    int n_miscompares = 0;
    logic [5:0] exp_q [$];

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_increase_n  (key_increase_n),
        .key_decrease_n  (key_decrease_n),
        .key_change_n    (key_change_n),
        .pressed_increase(pressed_increase),
        .pressed_decrease(pressed_decrease),
        .pressed_change  (pressed_change),
        .butt_increase   (butt_increase),
        .butt_decrease   (butt_decrease),
        .butt_change     (butt_change)
    );

    always #5 clk = ~clk;

    // {pressed_change, pressed_decrease, pressed_increase, butt_change, butt_decrease, butt_increase}
    function automatic logic [5:0] observed();
        return {pressed_change, pressed_decrease, pressed_increase,
                butt_change, butt_decrease, butt_increase};
    endfunction

    function automatic logic [5:0] vec(input logic pc, input logic pd, input logic pi,
                                       input logic bc, input logic bd, input logic bi);
        return {pc, pd, pi, bc, bd, bi};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs for edge k are already driven; queue the expectation, take the edge, compare.
    task automatic step(input string tag, input int k, input logic [5:0] exp);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check($sformatf("%s@%0d", tag, k), observed(), exp_q.pop_front());
    endtask

    task automatic settle(input string tag);
        key_increase_n = 1'b1;
        key_decrease_n = 1'b1;
        key_change_n   = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check({tag, "_settle"}, observed(), 6'b0);
    endtask

    initial begin
        rst_n          = 1'b0;
        key_increase_n = 1'b1;
        key_decrease_n = 1'b1;
        key_change_n   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset", observed(), 6'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step("idle", k, 6'b0);

        // Clean press of change, held 30 edges
        for (int k = 0; k < 46; k++) begin
            key_change_n = (k < 30) ? 1'b0 : 1'b1;
            step("clean", k, vec(k >= 6 && k <= 35, 1'b0, 1'b0, k == 7, 1'b0, 1'b0));
        end
        settle("clean");

        // Bounce on increase: 2 low, 2 high, for 20 edges
        for (int k = 0; k < 30; k++) begin
            key_increase_n = (k < 20) ? logic'((k / 2) % 2) : 1'b1;
            step("bounce", k, 6'b0);
        end
        settle("bounce");

        // Auto-repeat on increase, held 40 edges
        for (int k = 0; k < 56; k++) begin
            key_increase_n = (k < 40) ? 1'b0 : 1'b1;
            step("repeat", k, vec(1'b0, 1'b0, k >= 6 && k <= 45, 1'b0, 1'b0,
                                  k == 7 || (k >= 17 && k < 46 && (k - 17) % 3 == 0)));
        end
        settle("repeat");

        // Conflict: decrease first, increase 3 edges later and held past decrease release
        for (int k = 0; k < 60; k++) begin
            key_decrease_n = (k < 33) ? 1'b0 : 1'b1;
            key_increase_n = (k >= 3 && k < 45) ? 1'b0 : 1'b1;
            step("conflict", k, vec(1'b0, k >= 6 && k <= 38, k >= 9 && k <= 50,
                                    1'b0, k == 7, 1'b0));
        end
        settle("conflict");

        // Reset while decrease is auto-repeating
        for (int k = 0; k < 22; k++) begin
            key_decrease_n = 1'b0;
            step("pre_rst", k, vec(1'b0, k >= 6, 1'b0, 1'b0,
                                   k == 7 || k == 17 || k == 20, 1'b0));
        end
        rst_n = 1'b0;
        #1;
        check("rst_async", observed(), 6'b0);
        for (int k = 0; k < 2; k++) step("in_rst", k, 6'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step("post_rst", k, vec(1'b0, k >= 6, 1'b0, 1'b0, k == 7, 1'b0));
        end
        settle("post_rst");

        // Change and increase pressed on the same edge
        for (int k = 0; k < 20; k++) begin
            key_change_n   = (k < 10) ? 1'b0 : 1'b1;
            key_increase_n = (k < 10) ? 1'b0 : 1'b1;
            step("simul", k, vec(k >= 6 && k <= 15, 1'b0, k >= 6 && k <= 15,
                                 k == 7, 1'b0, k == 7));
        end
        settle("simul");

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
